// File: rtl/mm_coproc_pkg.sv
// Shared definitions for the memory-mapped coprocessor front end:
// FSM state encoding and output buffer depth.
package mm_coproc_pkg;

    typedef enum logic [1:0] {
        FE_IDLE  = 2'd0,
        FE_READ  = 2'd1,
        FE_DRAIN = 2'd2
    } fe_state_e;

    // Two entries: one for the token on the output, one to absorb the
    // BRAM read that was already issued when backpressure appeared.
    localparam int FE_BUF_DEPTH = 2;

endpackage

// File: rtl/mm_fe_buf.sv
// Two-entry register FIFO. The head entry drives the output directly from
// a register so the consumer sees a stable token while it stalls.
module mm_fe_buf
    import mm_coproc_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] head_o,
    output logic [1:0]        count_o
);

    logic              wr_ptr_q;
    logic              rd_ptr_q;
    logic [1:0]        count_q;
    logic              pop_ok;
    logic [DATA_W-1:0] entry [FE_BUF_DEPTH];

    // A pop on an empty buffer is ignored so the pointers can never slip.
    assign pop_ok = pop_i && (count_q != 2'd0);

    genvar gi;
    generate
        for (gi = 0; gi < FE_BUF_DEPTH; gi++) begin : g_entry
            logic [DATA_W-1:0] data_q;

            // Write this storage slot when the write pointer selects it.
            always_ff @(posedge aclk or negedge aresetn) begin
                if (!aresetn) begin
                    data_q <= '0;
                end else if (push_i && (wr_ptr_q == 1'(gi))) begin
                    data_q <= push_data_i;
                end
            end

            assign entry[gi] = data_q;
        end
    endgenerate

    // Pointer and occupancy tracking; push and pop together leave count unchanged.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_i) begin
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (pop_ok) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({push_i, pop_ok})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign head_o  = entry[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/mm_front_end.sv
// Input-side front end: reads `size` tokens from the local BRAM starting at
// address 0 and streams them to the accelerator over valid/ready, pulsing
// done once the last token has been accepted.
module mm_front_end
    import mm_coproc_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              start,
    input  logic [ADDR_W:0]   size,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W:0] MAX_SIZE = (ADDR_W+1)'(1) << ADDR_W;
    localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W+1)'(1);

    fe_state_e       state_q;
    logic [ADDR_W:0] size_q;
    logic [ADDR_W:0] rd_cnt_q;
    logic [ADDR_W:0] sent_cnt_q;
    logic            inflight_q;
    logic            done_q;

    logic [1:0]      buf_count;
    logic            pop;
    logic [2:0]      occ_d;
    logic [ADDR_W:0] size_sat;
    logic            last_pop;

    // Requests larger than the address space are clamped to a full sweep.
    assign size_sat = (size > MAX_SIZE) ? MAX_SIZE : size;

    assign dout_valid = (buf_count != 2'd0);
    assign pop        = dout_valid && dout_ready;

    // Occupancy after this cycle's pop: tokens buffered plus the read in flight.
    // A pop implies at least one buffered token, so this cannot underflow.
    assign occ_d = {1'b0, buf_count} + {2'b00, inflight_q} - {2'b00, pop};

    assign mem_en   = (state_q == FE_READ) && (rd_cnt_q < size_q) && (occ_d < 3'd2);
    assign mem_addr = rd_cnt_q[ADDR_W-1:0];
    assign last_pop = pop && ((sent_cnt_q + CNT_ONE) == size_q);

    assign busy = (state_q != FE_IDLE);
    assign done = done_q;

    // Transfer FSM, read/sent counters, read-in-flight flag and done pulse.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q    <= FE_IDLE;
            size_q     <= '0;
            rd_cnt_q   <= '0;
            sent_cnt_q <= '0;
            inflight_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            inflight_q <= mem_en;
            if (mem_en) begin
                rd_cnt_q <= rd_cnt_q + CNT_ONE;
            end
            if (pop) begin
                sent_cnt_q <= sent_cnt_q + CNT_ONE;
            end
            case (state_q)
                FE_IDLE: begin
                    if (start) begin
                        if (size == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            size_q     <= size_sat;
                            rd_cnt_q   <= '0;
                            sent_cnt_q <= '0;
                            state_q    <= FE_READ;
                        end
                    end
                end
                FE_READ: begin
                    // The last token cannot be popped before its read issues,
                    // so completion is only detected in DRAIN.
                    if (mem_en && ((rd_cnt_q + CNT_ONE) == size_q)) begin
                        state_q <= FE_DRAIN;
                    end
                end
                FE_DRAIN: begin
                    if (last_pop) begin
                        state_q <= FE_IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= FE_IDLE;
                end
            endcase
        end
    end

    mm_fe_buf #(
        .DATA_W (DATA_W)
    ) u_buf (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .push_i      (inflight_q),
        .push_data_i (mem_rdata),
        .pop_i       (pop),
        .head_o      (dout),
        .count_o     (buf_count)
    );

endmodule

// File: tb/tb_mm_front_end.sv
// Directed bench for mm_front_end with a BRAM model returning 0x100+addr and
// a scoreboard queue of expected tokens filled when a transfer is started.
module tb_mm_front_end;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 10;

    logic              aclk;
    logic              aresetn;
    logic              start;
    logic [ADDR_W:0]   size;
    logic              mem_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] dout;
    logic              dout_valid;
    logic              dout_ready;
    logic              busy;
    logic              done;

    mm_front_end #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_dut (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .start      (start),
        .size       (size),
        .mem_en     (mem_en),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .busy       (busy),
        .done       (done)
    );

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    // BRAM model with one cycle of read latency.
    initial mem_rdata = '0;
    always @(posedge aclk) begin
        if (mem_en) mem_rdata <= 32'h100 + {22'd0, mem_addr};
    end

    int passed = 0;
    int total  = 0;

    logic [31:0] exp_q [$];
    int          exp_addr;
    int          issued, popped;
    int          cyc_n, rdy_mode;
    int          mem_en_cnt, pop_cnt, done_cnt;
    int          first_mem_en, first_valid, done_cyc, busy_first, busy_last;
    logic        prev_stall;
    logic [31:0] prev_dout;
    logic [7:0]  rdy_pat;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic test_begin();
        cyc_n        = 0;
        mem_en_cnt   = 0;
        pop_cnt      = 0;
        done_cnt     = 0;
        first_mem_en = -1;
        first_valid  = -1;
        done_cyc     = -1;
        busy_first   = -1;
        busy_last    = -1;
    endtask

    task automatic push_tokens(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(32'h100 + i);
        exp_addr = 0;
    endtask

    // One clock cycle: drive ready, observe at the falling edge, return just
    // after the next rising edge where the caller may drive new inputs.
    task automatic cyc();
        case (rdy_mode)
            0:       dout_ready = 1'b1;
            1:       dout_ready = rdy_pat[7 - (cyc_n % 8)];
            default: dout_ready = 1'b0;
        endcase
        @(negedge aclk);
        if (aresetn) begin
            check("occupancy", 64'((issued - popped) <= 2), 64'd1);
            if (mem_en) begin
                check("addr", 64'(mem_addr), 64'(exp_addr[ADDR_W-1:0]));
                exp_addr++;
                issued++;
                mem_en_cnt++;
                if (first_mem_en < 0) first_mem_en = cyc_n;
            end
            if (prev_stall) begin
                check("stall_valid", 64'(dout_valid), 64'd1);
                check("stall_data", 64'(dout), 64'(prev_dout));
            end
            if (dout_valid && first_valid < 0) first_valid = cyc_n;
            if (dout_valid && dout_ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_token", 64'(dout), 64'hdead);
                end else begin
                    check("data", 64'(dout), 64'(exp_q.pop_front()));
                end
                popped++;
                pop_cnt++;
            end
            prev_stall = dout_valid && !dout_ready;
            prev_dout  = dout;
            if (done) begin
                done_cnt++;
                done_cyc = cyc_n;
            end
            if (busy) begin
                if (busy_first < 0) busy_first = cyc_n;
                busy_last = cyc_n;
            end
        end
        cyc_n++;
        @(posedge aclk);
        #1;
    endtask

    task automatic run_until_done(input int budget);
        int d0;
        int n;
        d0 = done_cnt;
        n  = 0;
        while (done_cnt == d0 && n < budget) begin
            cyc();
            n++;
        end
        check("done_timeout", 64'(done_cnt > d0), 64'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_mem_en"}, 64'(mem_en), 64'd0);
        check({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
        check({tag, "_dout"}, 64'(dout), 64'd0);
        check({tag, "_dout_valid"}, 64'(dout_valid), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
    endtask

    initial begin
        aresetn    = 1'b0;
        start      = 1'b0;
        size       = '0;
        dout_ready = 1'b0;
        rdy_mode   = 0;
        rdy_pat    = 8'b1001_0110;
        issued     = 0;
        popped     = 0;
        exp_addr   = 0;
        prev_stall = 1'b0;
        prev_dout  = '0;
        test_begin();

        // Reset state
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        check_reset_outputs("reset");
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        repeat (2) cyc();

        // Basic transfer, size 4, ready held high
        test_begin();
        rdy_mode = 0;
        start = 1'b1;
        size  = 11'd4;
        push_tokens(4);
        cyc();
        start = 1'b0;
        run_until_done(40);
        repeat (2) cyc();
        check("basic_first_mem_en", 64'(first_mem_en), 64'd1);
        check("basic_mem_en_cnt", 64'(mem_en_cnt), 64'd4);
        check("basic_first_valid", 64'(first_valid), 64'd3);
        check("basic_done_cyc", 64'(done_cyc), 64'd7);
        check("basic_done_cnt", 64'(done_cnt), 64'd1);
        check("basic_busy_first", 64'(busy_first), 64'd1);
        check("basic_busy_last", 64'(busy_last), 64'd6);
        check("basic_left", 64'(exp_q.size()), 64'd0);

        // Backpressure, size 8, ready pattern 1,0,0,1,0,1,1,0
        test_begin();
        rdy_mode = 1;
        start = 1'b1;
        size  = 11'd8;
        push_tokens(8);
        cyc();
        start = 1'b0;
        run_until_done(200);
        rdy_mode = 0;
        repeat (2) cyc();
        check("bp_pops", 64'(pop_cnt), 64'd8);
        check("bp_done_cnt", 64'(done_cnt), 64'd1);
        check("bp_left", 64'(exp_q.size()), 64'd0);

        // Zero size
        test_begin();
        start = 1'b1;
        size  = 11'd0;
        cyc();
        start = 1'b0;
        repeat (4) cyc();
        check("zero_mem_en_cnt", 64'(mem_en_cnt), 64'd0);
        check("zero_done_cyc", 64'(done_cyc), 64'd1);
        check("zero_done_cnt", 64'(done_cnt), 64'd1);
        check("zero_busy", 64'(busy_first), 64'hffff_ffff_ffff_ffff);

        // Start while busy is ignored
        test_begin();
        start = 1'b1;
        size  = 11'd5;
        push_tokens(5);
        cyc();
        start = 1'b0;
        cyc();
        start = 1'b1;
        size  = 11'd2;
        cyc();
        start = 1'b0;
        run_until_done(40);
        repeat (5) cyc();
        check("busy_start_pops", 64'(pop_cnt), 64'd5);
        check("busy_start_done_cnt", 64'(done_cnt), 64'd1);
        check("busy_start_mem_en_cnt", 64'(mem_en_cnt), 64'd5);
        check("busy_start_left", 64'(exp_q.size()), 64'd0);

        // Back-to-back: restart in the done cycle
        test_begin();
        start = 1'b1;
        size  = 11'd3;
        push_tokens(3);
        cyc();
        start = 1'b0;
        repeat (5) cyc();
        start = 1'b1;
        size  = 11'd2;
        push_tokens(2);
        cyc();
        start = 1'b0;
        check("b2b_first_done_cyc", 64'(done_cyc), 64'd6);
        first_mem_en = -1;
        run_until_done(40);
        repeat (2) cyc();
        check("b2b_restart_mem_en", 64'(first_mem_en), 64'd7);
        check("b2b_done_cnt", 64'(done_cnt), 64'd2);
        check("b2b_pops", 64'(pop_cnt), 64'd5);
        check("b2b_left", 64'(exp_q.size()), 64'd0);

        // Reset in cycle 4 of a stalled size-6 transfer
        test_begin();
        rdy_mode = 2;
        start = 1'b1;
        size  = 11'd6;
        push_tokens(6);
        cyc();
        start = 1'b0;
        repeat (3) cyc();
        check("rst_pre_busy", 64'(busy), 64'd1);
        aresetn = 1'b0;
        #1;
        check_reset_outputs("rst_mid");
        exp_q.delete();
        issued     = 0;
        popped     = 0;
        prev_stall = 1'b0;
        repeat (2) cyc();
        check("rst_hold_done", 64'(done), 64'd0);
        aresetn  = 1'b1;
        rdy_mode = 0;
        repeat (3) cyc();
        check("rst_no_done", 64'(done_cnt), 64'd0);
        test_begin();
        start = 1'b1;
        size  = 11'd1;
        push_tokens(1);
        cyc();
        start = 1'b0;
        run_until_done(40);
        check("rst_after_done_cyc", 64'(done_cyc), 64'd4);
        check("rst_after_pops", 64'(pop_cnt), 64'd1);
        check("rst_after_left", 64'(exp_q.size()), 64'd0);

        // Maximum size: full address sweep with no wrap
        test_begin();
        start = 1'b1;
        size  = 11'd1024;
        push_tokens(1024);
        cyc();
        start = 1'b0;
        run_until_done(1200);
        repeat (2) cyc();
        check("max_mem_en_cnt", 64'(mem_en_cnt), 64'd1024);
        check("max_pops", 64'(pop_cnt), 64'd1024);
        check("max_done_cyc", 64'(done_cyc), 64'd1027);
        check("max_left", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mm_front_end.md
Name: mm_front_end

Overview:
- Input-side companion of the memory-mapped coprocessor back-end controller.
- On a start pulse it reads `size` tokens sequentially from the local input BRAM, starting at address 0. The BRAM has 1-cycle read latency.
- It streams the tokens to the accelerator input port over a valid/ready handshake and pulses `done` once the last token is accepted.
- A 2-entry output buffer absorbs BRAM latency under backpressure and sustains 1 token/cycle.

Parameters:
- DATA_W, 32: token / BRAM data width.
- ADDR_W, 10: BRAM address width. Maximum transfer is 2^ADDR_W tokens.

Ports:
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- start  in  1  single-cycle request; sampled only in IDLE
- size  in  ADDR_W+1  token count, latched when start is accepted
- mem_en  out  1  BRAM read enable
- mem_addr  out  ADDR_W  BRAM read address
- mem_rdata  in  DATA_W  BRAM read data, valid the cycle after mem_en
- dout  out  DATA_W  token to accelerator
- dout_valid  out  1  dout holds a token
- dout_ready  in  1  accelerator accepts token
- busy  out  1  transfer in progress
- done  out  1  one-cycle pulse, transfer complete

Behaviour:
- Reset and clock: reset is aresetn, asynchronous, active-low; clock is aclk. All state updates on the rising edge of aclk.
- Reset values: state=IDLE, rd_cnt=0, sent_cnt=0, inflight=0, buffer empty. Outputs mem_en=0, mem_addr=0, dout=0, dout_valid=0, busy=0, done=0.
- States: IDLE, READ, DRAIN.
- IDLE:
  - start=1 and size!=0: latch size, clear rd_cnt/sent_cnt, go READ.
  - start=1 and size=0: stay IDLE, done=1 next cycle, no BRAM access.
  - size > 2^ADDR_W saturates to 2^ADDR_W.
- Issue rule in READ: mem_en = (rd_cnt < size_q) && (count + inflight - pop < 2), where pop = dout_valid && dout_ready.
  - mem_addr = rd_cnt[ADDR_W-1:0], driven combinationally.
  - rd_cnt increments on each issue; inflight <= mem_en.
- Capture: when inflight=1, mem_rdata is written into the buffer tail that cycle. The buffer never overflows; the issue rule guarantees it.
- Output: dout_valid = count!=0; dout = buffer head. On pop, advance head and increment sent_cnt.
  - dout and dout_valid come from registers; no combinational path from dout_ready to dout_valid.
  - mem_en does depend combinationally on dout_ready.
- Simultaneous capture and pop: count unchanged, data order preserved.
- READ -> DRAIN when the last address issues (rd_cnt reaches size_q).
- DRAIN:
  - No mem_en.
  - On the pop that makes sent_cnt == size_q: go IDLE, done=1 in the following cycle.
- busy = (state != IDLE).
- start while busy is ignored. A start in the same cycle done=1 is accepted (state is already IDLE).
- Latency, dout_ready=1, start high in cycle 0:
  - mem_en first high in cycle 1.
  - dout_valid first high in cycle 3.
  - Last token in cycle 2+N.
  - done in cycle 3+N.
- Throughput: 1 token/cycle sustained when dout_ready is held high.
- Backpressure: with dout_ready=0 the block holds at most 2 tokens (buffer plus inflight). dout and dout_valid stay stable until accepted.
- Reset mid-operation: everything returns to reset values immediately; inflight data is discarded; no done pulse.

Decomposition:
- Shared package (mm_coproc_pkg): state encoding constants FE_IDLE/FE_READ/FE_DRAIN, and the buffer depth constant FE_BUF_DEPTH=2.
- One natural sub-module: mm_fe_buf, a 2-entry register FIFO with push/pop/count. The main module keeps the FSM, counters and issue logic.

Test Plan:
- Basic transfer: BRAM model returns 0x100+addr; size=4, dout_ready=1, start in cycle 0.
  - mem_en in cycles 1–4, addresses 0–3.
  - dout 0x100..0x103 in cycles 3–6.
  - done=1 in cycle 7 only; busy high in cycles 1–6.
- Backpressure: size=8, dout_ready pattern 1,0,0,1,0,1,1,0,...
  - All 8 tokens in order, no duplicates or drops.
  - dout stable while valid&&!ready; count+inflight never exceeds 2.
- Zero size: size=0 -> no mem_en ever; done=1 in cycle 1; busy stays 0.
- Start while busy: second start with size=2 during a size=5 transfer -> ignored; exactly 5 tokens and one done.
- Back-to-back: start reasserted in the done cycle -> new transfer begins; mem_en in the next cycle, address 0.
- Reset mid-transfer: aresetn low in cycle 4 of a size=6 transfer with dout_ready=0.
  - All outputs return to reset values at once; no done.
  - A new start with size=1 after release completes normally.
- Maximum size: size=1024 with ADDR_W=10 -> addresses 0..1023 with no wrap; done after 1024 handshakes.
